// File: rtl/mem_trace_monitor_pkg.sv
// Shared types for the store-trace monitor: capture size encoding and the FIFO entry layout.
package trace_pkg;

   localparam int unsigned TR_ADDR_W = 32;
   localparam int unsigned TR_DATA_W = 32;
   localparam int unsigned TR_SEQ_W  = 16;

   typedef enum logic [1:0] {
      WORD = 2'b00,
      HALF = 2'b01,
      BYTE = 2'b10
   } trace_size_t;

   typedef struct packed {
      logic [TR_ADDR_W-1:0] addr;
      logic [TR_DATA_W-1:0] data;
      trace_size_t          size;
      logic [TR_ADDR_W-1:0] pc;
      logic [2:0]           win;
      logic [TR_SEQ_W-1:0]  seq;
   } trace_entry_t;

   // Byte strobe wins over half-word strobe.
   function automatic trace_size_t size_of(input logic is_byte, input logic is_half);
      if (is_byte) begin
         return BYTE;
      end else if (is_half) begin
         return HALF;
      end
      return WORD;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; entries are only visible once count says so.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/mem_trace_monitor.sv
// Captures stores hitting configured address windows into a drainable FIFO, and freezes
// capture once a halt instruction has been seen for HALT_CYCLES consecutive cycles.
module mem_trace_monitor
   import trace_pkg::*;
#(
   parameter int unsigned              ADDR_W      = 32,
   parameter int unsigned              DATA_W      = 32,
   parameter int unsigned              DEPTH       = 16,
   parameter int unsigned              NUM_WIN     = 2,
   parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE   = {32'h0000_3000, 32'h0000_2000},
   parameter logic [NUM_WIN*ADDR_W-1:0] WIN_MASK   = {32'hFFFF_FF00, 32'hFFFF_FF00},
   parameter logic [31:0]              HALT_INSTR  = 32'hFFFF_FFFF,
   parameter int unsigned              HALT_CYCLES = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       write_enable,
   input  logic                       mem_byte,
   input  logic                       mem_half_word,
   input  logic [0:ADDR_W-1]          addr,
   input  logic [0:DATA_W-1]          data_to_mem,
   input  logic [0:ADDR_W-1]          iaddr,
   input  logic [0:31]                instr,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [0:ADDR_W-1]          trace_addr,
   output logic [0:DATA_W-1]          trace_data,
   output logic [0:1]                 trace_size,
   output logic [0:ADDR_W-1]          trace_pc,
   output logic [0:2]                 trace_win,
   output logic [0:15]                trace_seq,
   output logic [0:$clog2(DEPTH)]     fifo_count,
   output logic                       overflow,
   output logic [0:15]                drop_count,
   output logic                       halted
);

   localparam int unsigned HCW = $clog2(HALT_CYCLES + 1);
   localparam int unsigned EW  = $bits(trace_entry_t);

   typedef enum logic {RUN, HALTED_ST} halt_state_t;

   halt_state_t        state_q, state_d;
   logic [HCW-1:0]     hcnt_q, hcnt_d;
   logic [15:0]        seq_q, seq_d;
   logic [15:0]        drop_q, drop_d;
   logic               ovf_q, ovf_d;

   logic               win_hit;
   logic [2:0]         win_idx;
   logic               hit, pop, push, drop;
   logic               fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0] fifo_cnt;
   trace_entry_t       wr_entry, rd_entry;
   logic [EW-1:0]      rd_bits;

   // Ascending scan keeps the first (lowest-index) matching window.
   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
         if (((addr & WIN_MASK[i*ADDR_W +: ADDR_W]) == WIN_BASE[i*ADDR_W +: ADDR_W]) && !win_hit) begin
            win_hit = 1'b1;
            win_idx = 3'(i);
         end
      end
   end

   always_comb begin
      hit  = write_enable & enable & (state_q == RUN) & win_hit;
      pop  = ~fifo_empty & trace_ready;
      push = hit & (~fifo_full | pop);
      drop = hit & fifo_full & ~pop;

      wr_entry      = '0;
      wr_entry.addr = TR_ADDR_W'(addr);
      wr_entry.data = TR_DATA_W'(data_to_mem);
      wr_entry.size = size_of(mem_byte, mem_half_word);
      wr_entry.pc   = TR_ADDR_W'(iaddr);
      wr_entry.win  = win_idx;
      wr_entry.seq  = seq_q;

      seq_d  = hit ? seq_q + 16'd1 : seq_q;
      ovf_d  = ovf_q | drop;
      drop_d = (drop && drop_q != '1) ? drop_q + 16'd1 : drop_q;
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      case (state_q)
         RUN: begin
            if (instr == HALT_INSTR) begin
               hcnt_d = hcnt_q + HCW'(1);
               if (hcnt_d == HCW'(HALT_CYCLES)) begin
                  state_d = HALTED_ST;
               end
            end else begin
               hcnt_d = '0;
            end
         end
         default: state_d = HALTED_ST;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         hcnt_q  <= '0;
         seq_q   <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         seq_q   <= seq_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clock),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   assign rd_entry    = trace_entry_t'(rd_bits);
   assign trace_valid = ~fifo_empty;
   assign trace_addr  = ADDR_W'(rd_entry.addr);
   assign trace_data  = DATA_W'(rd_entry.data);
   assign trace_size  = rd_entry.size;
   assign trace_pc    = ADDR_W'(rd_entry.pc);
   assign trace_win   = rd_entry.win;
   assign trace_seq   = rd_entry.seq;
   assign fifo_count  = fifo_cnt;
   assign overflow    = ovf_q;
   assign drop_count  = drop_q;
   assign halted      = (state_q == HALTED_ST);

endmodule

// File: tb/tb_mem_trace_monitor.sv
// Directed self-checking bench for mem_trace_monitor with default parameters.
module tb_mem_trace_monitor;

   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        write_enable = 1'b0;
   logic        mem_byte = 1'b0;
   logic        mem_half_word = 1'b0;
   logic [0:31] addr = '0;
   logic [0:31] data_to_mem = '0;
   logic [0:31] iaddr = '0;
   logic [0:31] instr = '0;
   logic        trace_ready = 1'b0;
   logic        trace_valid;
   logic [0:31] trace_addr;
   logic [0:31] trace_data;
   logic [0:1]  trace_size;
   logic [0:31] trace_pc;
   logic [0:2]  trace_win;
   logic [0:15] trace_seq;
   logic [0:4]  fifo_count;
   logic        overflow;
   logic [0:15] drop_count;
   logic        halted;

   int checks = 0;
   int errors = 0;

   mem_trace_monitor dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .write_enable  (write_enable),
      .mem_byte      (mem_byte),
      .mem_half_word (mem_half_word),
      .addr          (addr),
      .data_to_mem   (data_to_mem),
      .iaddr         (iaddr),
      .instr         (instr),
      .trace_valid   (trace_valid),
      .trace_ready   (trace_ready),
      .trace_addr    (trace_addr),
      .trace_data    (trace_data),
      .trace_size    (trace_size),
      .trace_pc      (trace_pc),
      .trace_win     (trace_win),
      .trace_seq     (trace_seq),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
      .drop_count    (drop_count),
      .halted        (halted)
   );

   always #5 clock = ~clock;

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      write_enable = 1'b0;
      mem_byte = 1'b0;
      mem_half_word = 1'b0;
      trace_ready = 1'b0;
      instr = '0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   // One store cycle: drive at the negedge, capture at the following posedge.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                        input logic b, input logic h);
      addr = a;
      data_to_mem = d;
      iaddr = pc;
      mem_byte = b;
      mem_half_word = h;
      write_enable = 1'b1;
      @(negedge clock);
      write_enable = 1'b0;
      mem_byte = 1'b0;
      mem_half_word = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", trace_valid); end
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%0b exp=0", overflow); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%0b exp=0", halted); end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_single();
      store(32'h2004, 32'h37, 32'h40, 1'b0, 1'b0);
      checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", trace_valid); end
      checks++; if (trace_addr !== 32'h2004) begin errors++; $display("FAIL single_addr got=%h exp=00002004", trace_addr); end
      checks++; if (trace_data !== 32'h37) begin errors++; $display("FAIL single_data got=%h exp=00000037", trace_data); end
      checks++; if (trace_size !== 2'b00) begin errors++; $display("FAIL single_size got=%b exp=00", trace_size); end
      checks++; if (trace_pc !== 32'h40) begin errors++; $display("FAIL single_pc got=%h exp=00000040", trace_pc); end
      checks++; if (trace_win !== 3'd0) begin errors++; $display("FAIL single_win got=%0d exp=0", trace_win); end
      checks++; if (trace_seq !== 16'd0) begin errors++; $display("FAIL single_seq got=%0d exp=0", trace_seq); end
      checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
      trace_ready = 1'b1;
      @(negedge clock);
      trace_ready = 1'b0;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL single_pop got=%0b exp=0", trace_valid); end
   endtask

   task automatic test_miss_priority();
      store(32'h4000, 32'h11, 32'h44, 1'b0, 1'b0);
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL miss_count got=%0d exp=0", fifo_count); end
      store(32'h3010, 32'hA5, 32'h48, 1'b1, 1'b1);
      checks++; if (trace_size !== 2'b10) begin errors++; $display("FAIL prio_size got=%b exp=10", trace_size); end
      checks++; if (trace_win !== 3'd1) begin errors++; $display("FAIL prio_win got=%0d exp=1", trace_win); end
      checks++; if (trace_seq !== 16'd1) begin errors++; $display("FAIL prio_seq got=%0d exp=1", trace_seq); end
      store(32'h2020, 32'hB6, 32'h4C, 1'b0, 1'b1);
      trace_ready = 1'b1;
      @(negedge clock);
      checks++; if (trace_size !== 2'b01) begin errors++; $display("FAIL half_size got=%b exp=01", trace_size); end
      @(negedge clock);
      trace_ready = 1'b0;
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL prio_drain got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) begin
         store(32'h2000 + 32'(i) * 4, 32'(i), 32'h100, 1'b0, 1'b0);
      end
      checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", fifo_count, DEPTH); end
      checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL ovf_drop got=%0d exp=3", drop_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
      trace_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (trace_seq !== 16'(i) || trace_data !== 32'(i)) begin
            errors++; $display("FAIL drain_seq got=%0d/%0d exp=%0d", trace_seq, trace_data, i);
         end
         @(negedge clock);
      end
      trace_ready = 1'b0;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", trace_valid); end
      store(32'h2000, 32'hAA, 32'h104, 1'b0, 1'b0);
      checks++; if (trace_seq !== 16'(DEPTH + 3)) begin errors++; $display("FAIL gap_seq got=%0d exp=%0d", trace_seq, DEPTH + 3); end
      trace_ready = 1'b1;
      @(negedge clock);
      trace_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < DEPTH; i++) begin
         store(32'h2000, 32'(i), 32'h200, 1'b0, 1'b0);
      end
      checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL full_count got=%0d exp=%0d", fifo_count, DEPTH); end
      trace_ready = 1'b1;
      store(32'h2000, 32'hFF, 32'h204, 1'b0, 1'b0);
      trace_ready = 1'b0;
      checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL fullpop_count got=%0d exp=%0d", fifo_count, DEPTH); end
      checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL fullpop_drop got=%0d exp=3", drop_count); end
      checks++; if (trace_seq !== 16'd21) begin errors++; $display("FAIL fullpop_head got=%0d exp=21", trace_seq); end
      trace_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clock);
      end
      trace_ready = 1'b0;
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL fullpop_drain got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_halt();
      do_reset();
      instr = 32'hFFFF_FFFF;
      @(negedge clock);
      instr = 32'h0000_0013;
      @(negedge clock);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_single got=%0b exp=0", halted); end
      instr = 32'hFFFF_FFFF;
      @(negedge clock);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_partial got=%0b exp=0", halted); end
      store(32'h2008, 32'h55, 32'h300, 1'b0, 1'b0);
      instr = 32'h0000_0013;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%0b exp=1", halted); end
      checks++; if (trace_valid !== 1'b1 || trace_addr !== 32'h2008) begin
         errors++; $display("FAIL halt_capture got=%0b/%h exp=1/00002008", trace_valid, trace_addr);
      end
      store(32'h2010, 32'h66, 32'h304, 1'b0, 1'b0);
      checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL halt_ignore got=%0d exp=1", fifo_count); end
      trace_ready = 1'b1;
      @(negedge clock);
      trace_ready = 1'b0;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL halt_drain got=%0b exp=0", trace_valid); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got=%0b exp=1", halted); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         store(32'h3000, 32'(i), 32'h400, 1'b0, 1'b0);
      end
      checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL areset_pre got=%0d exp=5", fifo_count); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b exp=0", trace_valid); end
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", fifo_count); end
      #1;
      reset = 1'b1;
      @(negedge clock);
      store(32'h3004, 32'h77, 32'h404, 1'b0, 1'b0);
      checks++; if (trace_seq !== 16'd0 || trace_win !== 3'd1) begin
         errors++; $display("FAIL areset_seq got=%0d/%0d exp=0/1", trace_seq, trace_win);
      end
      checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL areset_count2 got=%0d exp=1", fifo_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_miss_priority();
      test_overflow();
      test_full_pop();
      test_halt();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
